// File: rtl/interrupt_controller.sv
// Eight-line rising-edge interrupt controller: synchronizers, pending/mask
// registers and a non-nesting IDLE/REQUEST/SERVICE handshake with the core.
module interrupt_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] irq_in_i,
    input  logic       mask_we_i,
    input  logic [7:0] mask_in_i,
    input  logic       irq_ack_i,
    input  logic       irq_eoi_i,
    output logic       irq_req_o,
    output logic [2:0] irq_id_o,
    output logic [7:0] pending_o,
    output logic [7:0] mask_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_e;

    state_e                        state_q, state_d;
    logic [SYNC_STAGES-1:0][7:0]   sync_q;
    logic [7:0]                    hist_q;
    logic [SYNC_STAGES:0]          arm_q;
    logic [7:0]                    pending_q, pending_d;
    logic [7:0]                    mask_q, mask_d;
    logic                          req_q, req_d;
    logic [2:0]                    id_q, id_d;
    logic [7:0]                    rise, elig, clr;
    logic [2:0]                    top_id;

    // arm_q tracks which pipeline stages hold samples taken after reset, so a
    // line held high through reset is never mistaken for a fresh edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in_i};
            hist_q <= sync_q[SYNC_STAGES-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q & {8{arm_q[SYNC_STAGES]}};
    assign elig = pending_q & mask_q;

    always_comb begin
        top_id = '0;
        for (int i = 0; i < 8; i++)
            if (elig[i]) top_id = 3'(i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|elig) state_d = REQUEST;
            REQUEST: begin
                if (irq_ack_i)            state_d = SERVICE;
                else if (!mask_q[id_q])   state_d = IDLE;
            end
            SERVICE: if (irq_eoi_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d = 1'b0;
        id_d  = id_q;
        clr   = '0;
        case (state_q)
            IDLE: if (|elig) begin
                req_d = 1'b1;
                id_d  = top_id;
            end
            REQUEST: begin
                if (irq_ack_i)          clr   = 8'(1) << id_q;
                else if (mask_q[id_q])  req_d = 1'b1;
            end
            default: ;
        endcase
    end

    // A new edge on a bit being acknowledged keeps that bit pending.
    assign pending_d = (pending_q & ~clr) | rise;
    assign mask_d    = mask_we_i ? mask_in_i : mask_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            mask_q    <= '0;
            req_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    assign irq_req_o = req_q;
    assign irq_id_o  = id_q;
    assign pending_o = pending_q;
    assign mask_o    = mask_q;
    assign busy_o    = (state_q == SERVICE);

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: stimulus pushes the expected offered IDs, a monitor pops
// and checks them on each new IRQ request; register state is checked inline.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_in;
    logic       ack, eoi;
    logic       irq_req;
    logic [2:0] irq_id;
    logic [7:0] pending, mask;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    logic req_seen = 1'b0;

    interrupt_controller #(.SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .irq_in_i(irq_in),
        .mask_we_i(mask_we), .mask_in_i(mask_in),
        .irq_ack_i(ack), .irq_eoi_i(eoi),
        .irq_req_o(irq_req), .irq_id_o(irq_id),
        .pending_o(pending), .mask_o(mask), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_in = m;
        cyc(1);
        mask_we = 1'b0;
    endtask

    task automatic wait_offer(input string name);
        int n = 0;
        while (!irq_req && n < 20) begin
            cyc(1);
            n++;
        end
        chk(name, irq_req, 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        cyc(1);
        eoi = 1'b0;
    endtask

    // Monitor: every new rising request must match the next expected ID.
    always @(negedge clk) begin
        if (irq_req && !req_seen) begin
            req_seen <= 1'b1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_offer: got id %0d expected none at %0t", irq_id, $time);
            end else begin
                chk("offer_id", 32'(irq_id), 32'(exp_q.pop_front()));
            end
        end else if (!irq_req) begin
            req_seen <= 1'b0;
        end
    end

    initial begin
        rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_in = '0; ack = 1'b0; eoi = 1'b0;
        cyc(2);
        chk("rst_req", irq_req, 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        cyc(5);

        // Single line: exact latency and full handshake
        wr_mask(8'hFF);
        chk("mask_ff", 32'(mask), 32'hFF);
        exp_q.push_back(3);
        irq_in[3] = 1'b1;
        cyc(2);
        chk("lat_pend_n1", 32'(pending), 0);
        cyc(1);
        chk("lat_pend_n2", 32'(pending), 32'h08);
        chk("lat_req_n2", irq_req, 0);
        cyc(1);
        chk("lat_req_n3", irq_req, 1);
        chk("lat_id_n3", 32'(irq_id), 3);
        do_ack();
        chk("ack_pending", 32'(pending), 0);
        chk("ack_busy", busy, 1);
        chk("ack_req", irq_req, 0);
        chk("ack_id_kept", 32'(irq_id), 3);
        cyc(2);
        chk("svc_busy_hold", busy, 1);
        do_eoi();
        chk("eoi_busy", busy, 0);
        irq_in = '0;
        cyc(4);

        // Two simultaneous lines: highest index first, back-to-back second
        exp_q.push_back(6);
        irq_in[1] = 1'b1; irq_in[6] = 1'b1;
        wait_offer("prio_offer");
        chk("prio_pending", 32'(pending), 32'h42);
        do_ack();
        exp_q.push_back(1);
        do_eoi();
        chk("b2b_idle_req", irq_req, 0);
        cyc(1);
        chk("b2b_req", irq_req, 1);
        chk("b2b_id", 32'(irq_id), 1);
        do_ack();
        do_eoi();
        irq_in = '0;
        cyc(4);

        // Masked line stays pending, mask write releases it
        wr_mask(8'h00);
        irq_in[5] = 1'b1;
        cyc(5);
        chk("masked_pending", 32'(pending), 32'h20);
        chk("masked_req", irq_req, 0);
        exp_q.push_back(5);
        wr_mask(8'h20);
        chk("unmask_req_early", irq_req, 0);
        cyc(1);
        chk("unmask_req", irq_req, 1);
        chk("unmask_id", 32'(irq_id), 5);
        do_ack();
        do_eoi();
        irq_in = '0;
        cyc(4);

        // Withdrawal on mask clear, then ACK beating withdrawal
        wr_mask(8'hFF);
        exp_q.push_back(4);
        irq_in[4] = 1'b1;
        wait_offer("wd_offer");
        wr_mask(8'hEF);
        chk("wd_req_hold", irq_req, 1);
        cyc(1);
        chk("wd_req", irq_req, 0);
        chk("wd_pending", 32'(pending), 32'h10);
        chk("wd_busy", busy, 0);
        cyc(2);
        chk("wd_idle", irq_req, 0);
        exp_q.push_back(4);
        wr_mask(8'hFF);
        wait_offer("wd_reoffer");
        wr_mask(8'hEF);
        do_ack();
        chk("ackwin_busy", busy, 1);
        chk("ackwin_pending", 32'(pending), 0);
        do_eoi();
        wr_mask(8'hFF);
        irq_in = '0;
        cyc(4);

        // Non-nesting during SERVICE; stray ACK/EOI ignored
        exp_q.push_back(7);
        irq_in[7] = 1'b1;
        wait_offer("svc_offer");
        do_eoi();
        chk("stray_eoi_req", irq_req, 1);
        chk("stray_eoi_id", 32'(irq_id), 7);
        do_ack();
        irq_in[2] = 1'b1;
        cyc(5);
        chk("nest_pending", 32'(pending), 32'h04);
        chk("nest_req", irq_req, 0);
        chk("nest_busy", busy, 1);
        exp_q.push_back(2);
        do_eoi();
        cyc(1);
        chk("post_eoi_req", irq_req, 1);
        chk("post_eoi_id", 32'(irq_id), 2);
        do_ack();
        do_eoi();
        do_ack();
        chk("stray_ack_busy", busy, 0);
        irq_in = '0;
        cyc(4);

        // New edge on the bit being acknowledged keeps it pending
        exp_q.push_back(0);
        irq_in[0] = 1'b1;
        wait_offer("setwin_offer");
        irq_in[0] = 1'b0;
        cyc(3);
        irq_in[0] = 1'b1;
        cyc(2);
        do_ack();
        chk("setwin_busy", busy, 1);
        chk("setwin_pending", 32'(pending), 32'h01);
        exp_q.push_back(0);
        do_eoi();
        wait_offer("setwin_reoffer");
        do_ack();
        do_eoi();
        chk("setwin_clear", 32'(pending), 0);
        irq_in = '0;
        cyc(4);

        // Reset during SERVICE with all lines held high
        exp_q.push_back(7);
        irq_in = 8'hFF;
        wait_offer("rst_offer");
        do_ack();
        chk("rst_pre_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", irq_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_pending", 32'(pending), 0);
        chk("arst_mask", 32'(mask), 0);
        chk("arst_id", 32'(irq_id), 0);
        cyc(2);
        rst = 1'b0;
        wr_mask(8'hFF);
        cyc(10);
        chk("held_pending", 32'(pending), 0);
        chk("held_req", irq_req, 0);
        irq_in[3] = 1'b0;
        cyc(4);
        exp_q.push_back(3);
        irq_in[3] = 1'b1;
        wait_offer("refire_offer");
        chk("refire_pending", 32'(pending), 32'h08);
        do_ack();
        do_eoi();
        irq_in = '0;
        cyc(5);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
